// File: rtl/mm_bus_router.sv
// mm_bus_router
//   Routes single-outstanding request/response transactions from N_MASTER
//   masters to N_SLAVE address-decoded slaves.
//
//   Each master runs an IDLE / WAIT_RESP / ERR_RESP FSM. Each slave runs a
//   FREE / BUSY FSM with a registered owner and a round-robin pointer.
//   An unmapped address is granted at once and answered one cycle later
//   with an error response. No slave sees an unmapped request.
//
//   Handshake semantics:
//     request phase  - a transfer happens in the cycle where req and gnt are
//                      both 1. Master req/addr/we/be/wdata are forwarded
//                      combinationally to the selected slave, and the slave's
//                      gnt is reflected combinationally to that master.
//     response phase - a slave's rvalid, seen while the slave is BUSY, is
//                      forwarded in the same cycle to the owning master.
//                      A slave has no back-pressure on its response.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   m_*_i / m_*_o     master side, packed per master (index m at slice m)
//   s_*_o / s_*_i     slave side, packed per slave (index k at slice k)
//   dbg_m_state       2-bit state of each master FSM (IDLE=0, WAIT=1, ERR=2)
//   dbg_s_state       state of each slave FSM (FREE=0, BUSY=1)
module mm_bus_router #(
    parameter int N_MASTER   = 3,
    parameter int N_SLAVE    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [N_SLAVE*ADDR_WIDTH-1:0] START_ADDR =
        {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
    parameter logic [N_SLAVE*ADDR_WIDTH-1:0] END_ADDR =
        {32'h1A11_FFFF, 32'h0FFF_FFFF, 32'h000F_FFFF}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTER-1:0]            m_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [N_MASTER-1:0]            m_we_i,
    input  logic [N_MASTER*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0] m_wdata_i,
    output logic [N_MASTER-1:0]            m_gnt_o,
    output logic [N_MASTER-1:0]            m_rvalid_o,
    output logic [N_MASTER*DATA_WIDTH-1:0] m_rdata_o,
    output logic [N_MASTER-1:0]            m_err_o,
    output logic [N_SLAVE-1:0]             s_req_o,
    output logic [N_SLAVE*ADDR_WIDTH-1:0]  s_addr_o,
    output logic [N_SLAVE-1:0]             s_we_o,
    output logic [N_SLAVE*DATA_WIDTH/8-1:0] s_be_o,
    output logic [N_SLAVE*DATA_WIDTH-1:0]  s_wdata_o,
    input  logic [N_SLAVE-1:0]             s_gnt_i,
    input  logic [N_SLAVE-1:0]             s_rvalid_i,
    input  logic [N_SLAVE*DATA_WIDTH-1:0]  s_rdata_i,
    output logic [2*N_MASTER-1:0]          dbg_m_state,
    output logic [N_SLAVE-1:0]             dbg_s_state
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int MW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int SW = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

    typedef enum logic [1:0] {
        M_IDLE      = 2'd0,
        M_WAIT_RESP = 2'd1,
        M_ERR_RESP  = 2'd2
    } m_state_t;

    typedef enum logic {
        S_FREE = 1'b0,
        S_BUSY = 1'b1
    } s_state_t;

    m_state_t m_state [N_MASTER];
    m_state_t m_state_next [N_MASTER];
    s_state_t s_state [N_SLAVE];
    s_state_t s_state_next [N_SLAVE];

    logic [MW-1:0] owner [N_SLAVE];
    logic [MW-1:0] owner_next [N_SLAVE];
    logic [MW-1:0] ptr [N_SLAVE];
    logic [MW-1:0] ptr_next [N_SLAVE];
    // Master left waiting on s_gnt_i=0 last cycle; it keeps the slave while
    // it still requests so a stalled request is never re-arbitrated.
    logic [MW-1:0] hold_idx [N_SLAVE];
    logic [MW-1:0] hold_idx_next [N_SLAVE];
    logic [N_SLAVE-1:0] hold_valid;
    logic [N_SLAVE-1:0] hold_valid_next;

    logic [N_MASTER-1:0] mapped;
    logic [SW-1:0]       dec_slave [N_MASTER];
    logic [N_MASTER-1:0] cand [N_SLAVE];
    logic [N_SLAVE-1:0]  sel_valid;
    logic [MW-1:0]       sel_idx [N_SLAVE];

    // Address decode; descending scan so the lowest matching region wins.
    always_comb begin
        for (int m = 0; m < N_MASTER; m++) begin
            mapped[m]    = 1'b0;
            dec_slave[m] = '0;
            for (int k = N_SLAVE - 1; k >= 0; k--) begin
                if (m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= START_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH] &&
                    m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] <= END_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    mapped[m]    = 1'b1;
                    dec_slave[m] = SW'(k);
                end
            end
        end
    end

    // Masters eligible to compete for each slave.
    always_comb begin
        for (int s = 0; s < N_SLAVE; s++) begin
            cand[s] = '0;
            for (int m = 0; m < N_MASTER; m++) begin
                cand[s][m] = (m_state[m] == M_IDLE) && m_req_i[m] && mapped[m] &&
                             (int'(dec_slave[m]) == s);
            end
        end
    end

    // Round-robin selection, starting at the slave pointer.
    always_comb begin
        int idx;
        idx       = 0;
        sel_valid = '0;
        for (int s = 0; s < N_SLAVE; s++) begin
            sel_idx[s] = '0;
            if (s_state[s] == S_FREE) begin
                if (hold_valid[s]) begin
                    for (int m = 0; m < N_MASTER; m++) begin
                        if (hold_idx[s] == MW'(m) && cand[s][m]) begin
                            sel_valid[s] = 1'b1;
                            sel_idx[s]   = MW'(m);
                        end
                    end
                end
                for (int i = 0; i < N_MASTER; i++) begin
                    idx = int'(ptr[s]) + i;
                    if (idx >= N_MASTER) idx = idx - N_MASTER;
                    for (int m = 0; m < N_MASTER; m++) begin
                        if (!sel_valid[s] && idx == m && cand[s][m]) begin
                            sel_valid[s] = 1'b1;
                            sel_idx[s]   = MW'(m);
                        end
                    end
                end
            end
        end
    end

    // Slave-side request forwarding; data outputs are zero when not requesting.
    always_comb begin
        s_req_o   = '0;
        s_addr_o  = '0;
        s_we_o    = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        for (int s = 0; s < N_SLAVE; s++) begin
            for (int m = 0; m < N_MASTER; m++) begin
                if (sel_valid[s] && sel_idx[s] == MW'(m)) begin
                    s_req_o[s]                            = 1'b1;
                    s_addr_o[s*ADDR_WIDTH +: ADDR_WIDTH]  = m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
                    s_we_o[s]                             = m_we_i[m];
                    s_be_o[s*BW +: BW]                    = m_be_i[m*BW +: BW];
                    s_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Master-side grant and response.
    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_err_o    = '0;
        m_rdata_o  = '0;
        for (int m = 0; m < N_MASTER; m++) begin
            if (m_state[m] == M_IDLE && m_req_i[m] && !mapped[m]) m_gnt_o[m] = 1'b1;
            if (m_state[m] == M_ERR_RESP) begin
                m_rvalid_o[m] = 1'b1;
                m_err_o[m]    = 1'b1;
            end
        end
        for (int s = 0; s < N_SLAVE; s++) begin
            for (int m = 0; m < N_MASTER; m++) begin
                if (sel_valid[s] && sel_idx[s] == MW'(m)) m_gnt_o[m] = s_gnt_i[s];
                if (s_state[s] == S_BUSY && s_rvalid_i[s] && owner[s] == MW'(m)) begin
                    m_rvalid_o[m]                         = 1'b1;
                    m_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = s_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Next-state logic for master and slave FSMs.
    always_comb begin
        for (int m = 0; m < N_MASTER; m++) begin
            m_state_next[m] = m_state[m];
            case (m_state[m])
                M_IDLE: begin
                    if (m_gnt_o[m]) m_state_next[m] = mapped[m] ? M_WAIT_RESP : M_ERR_RESP;
                end
                M_WAIT_RESP: begin
                    if (m_rvalid_o[m]) m_state_next[m] = M_IDLE;
                end
                M_ERR_RESP: m_state_next[m] = M_IDLE;
                default:    m_state_next[m] = M_IDLE;
            endcase
        end
        for (int s = 0; s < N_SLAVE; s++) begin
            s_state_next[s]    = s_state[s];
            owner_next[s]      = owner[s];
            ptr_next[s]        = ptr[s];
            hold_idx_next[s]   = hold_idx[s];
            hold_valid_next[s] = 1'b0;
            case (s_state[s])
                S_FREE: begin
                    if (sel_valid[s]) begin
                        if (s_gnt_i[s]) begin
                            s_state_next[s] = S_BUSY;
                            owner_next[s]   = sel_idx[s];
                            ptr_next[s]     = (int'(sel_idx[s]) + 1 >= N_MASTER) ? '0
                                                                                  : sel_idx[s] + 1'b1;
                        end else begin
                            hold_valid_next[s] = 1'b1;
                            hold_idx_next[s]   = sel_idx[s];
                        end
                    end
                end
                S_BUSY: begin
                    if (s_rvalid_i[s]) s_state_next[s] = S_FREE;
                end
                default: s_state_next[s] = S_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < N_MASTER; m++) m_state[m] <= M_IDLE;
            for (int s = 0; s < N_SLAVE; s++) begin
                s_state[s]  <= S_FREE;
                owner[s]    <= '0;
                ptr[s]      <= '0;
                hold_idx[s] <= '0;
            end
            hold_valid <= '0;
        end else begin
            for (int m = 0; m < N_MASTER; m++) m_state[m] <= m_state_next[m];
            for (int s = 0; s < N_SLAVE; s++) begin
                s_state[s]  <= s_state_next[s];
                owner[s]    <= owner_next[s];
                ptr[s]      <= ptr_next[s];
                hold_idx[s] <= hold_idx_next[s];
            end
            hold_valid <= hold_valid_next;
        end
    end

    always_comb begin
        for (int m = 0; m < N_MASTER; m++) dbg_m_state[2*m +: 2] = m_state[m];
        for (int s = 0; s < N_SLAVE; s++) dbg_s_state[s] = s_state[s];
    end

endmodule

// File: tb/tb_mm_bus_router.sv
// Testbench for mm_bus_router with the default 3x3 configuration.
module tb_mm_bus_router;

    logic        clk;
    logic        rst;
    logic [2:0]  m_req_i;
    logic [95:0] m_addr_i;
    logic [2:0]  m_we_i;
    logic [11:0] m_be_i;
    logic [95:0] m_wdata_i;
    logic [2:0]  m_gnt_o;
    logic [2:0]  m_rvalid_o;
    logic [95:0] m_rdata_o;
    logic [2:0]  m_err_o;
    logic [2:0]  s_req_o;
    logic [95:0] s_addr_o;
    logic [2:0]  s_we_o;
    logic [11:0] s_be_o;
    logic [95:0] s_wdata_o;
    logic [2:0]  s_gnt_i;
    logic [2:0]  s_rvalid_i;
    logic [95:0] s_rdata_i;
    logic [5:0]  dbg_m_state;
    logic [2:0]  dbg_s_state;

    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    mm_bus_router dut (
        .clk(clk), .rst(rst),
        .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
        .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .dbg_m_state(dbg_m_state), .dbg_s_state(dbg_s_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_req_i    = '0;
        m_addr_i   = '0;
        m_we_i     = '0;
        m_be_i     = '0;
        m_wdata_i  = '0;
        s_gnt_i    = '0;
        s_rvalid_i = '0;
        s_rdata_i  = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if ({m_gnt_o, m_rvalid_o, m_err_o} !== 9'd0) begin errors++;
                $display("FAIL reset_m_ctrl: got %b exp 0", {m_gnt_o, m_rvalid_o, m_err_o}); end
            checks++; if (m_rdata_o !== 96'd0) begin errors++;
                $display("FAIL reset_m_rdata: got %h exp 0", m_rdata_o); end
            checks++; if (s_req_o !== 3'd0) begin errors++;
                $display("FAIL reset_s_req: got %b exp 0", s_req_o); end
            checks++; if ({s_addr_o, s_we_o, s_be_o, s_wdata_o} !== 207'd0) begin errors++;
                $display("FAIL reset_s_data: got %h exp 0", {s_addr_o, s_we_o, s_be_o, s_wdata_o}); end
            checks++; if ({dbg_m_state, dbg_s_state} !== 9'd0) begin errors++;
                $display("FAIL reset_state: got %b exp 0", {dbg_m_state, dbg_s_state}); end
            step();
            rst = 1'b0;
        end
    endtask

    task automatic test_single_read();
        logic [31:0] exp;
        apply_reset();
        m_req_i[0] = 1'b1; m_addr_i[31:0] = 32'h0000_0010; m_be_i[3:0] = 4'hF; s_gnt_i[0] = 1'b1;
        @(negedge clk);
        checks++; if (m_gnt_o !== 3'b001) begin errors++;
            $display("FAIL single_gnt: got %b exp 001", m_gnt_o); end
        checks++; if (s_req_o !== 3'b001 || s_addr_o[31:0] !== 32'h10 || s_be_o[3:0] !== 4'hF) begin errors++;
            $display("FAIL single_fwd: got req=%b addr=%h be=%h exp 001/10/f", s_req_o, s_addr_o[31:0], s_be_o[3:0]); end
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        m_req_i[0] = 1'b0; s_gnt_i[0] = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            checks++; if (m_rvalid_o !== 3'd0 || s_req_o !== 3'd0) begin errors++;
                $display("FAIL single_wait: got rvalid=%b req=%b exp 0/0", m_rvalid_o, s_req_o); end
            step();
        end
        s_rvalid_i[0] = 1'b1; s_rdata_i[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (m_rvalid_o !== 3'b001 || m_err_o !== 3'd0 || m_rdata_o[31:0] !== exp) begin errors++;
            $display("FAIL single_resp: got rvalid=%b err=%b data=%h exp 001/0/%h", m_rvalid_o, m_err_o, m_rdata_o[31:0], exp); end
        step();
        s_rvalid_i = '0; s_rdata_i = '0;
        @(negedge clk);
        checks++; if (m_rvalid_o !== 3'd0 || m_rdata_o !== 96'd0) begin errors++;
            $display("FAIL single_after: got rvalid=%b data=%h exp 0", m_rvalid_o, m_rdata_o); end
        step();
    endtask

    task automatic test_contention();
        logic [31:0] exp;
        logic        rv_pend;
        int          rv_owner, last_rv, cyc, gnt_idx;
        logic [31:0] rv_data;
        apply_reset();
        for (int m = 0; m < 3; m++) m_addr_i[m*32 +: 32] = 32'h1A10_0000 + 32'(m * 16);
        s_gnt_i = 3'b100;
        exp_q.delete();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        rv_pend = 1'b0; rv_owner = 0; rv_data = '0; last_rv = -1; cyc = 0;
        while ((exp_q.size() > 0 || rv_pend) && cyc < 40) begin
            m_req_i = (exp_q.size() > 0) ? 3'b111 : 3'b000;
            s_rvalid_i = rv_pend ? 3'b100 : 3'b000;
            s_rdata_i[95:64] = rv_pend ? rv_data : 32'd0;
            @(negedge clk);
            if (rv_pend) begin
                checks++; if (m_rvalid_o !== (3'b001 << rv_owner) || m_rdata_o[rv_owner*32 +: 32] !== rv_data) begin errors++;
                    $display("FAIL cont_resp: got rvalid=%b data=%h exp master %0d data %h", m_rvalid_o, m_rdata_o, rv_owner, rv_data); end
                last_rv = cyc;
            end
            if (m_gnt_o !== 3'd0) begin
                gnt_idx = 0;
                for (int m = 0; m < 3; m++) if (m_gnt_o[m]) gnt_idx = m;
                checks++;
                if (exp_q.size() == 0) begin errors++;
                    $display("FAIL cont_extra_gnt: got %b exp none", m_gnt_o); end
                else begin
                    exp = exp_q.pop_front();
                    if (m_gnt_o !== (3'b001 << exp)) begin errors++;
                        $display("FAIL cont_order: got %b exp master %0d", m_gnt_o, exp); end
                end
                if (last_rv >= 0) begin
                    checks++; if (cyc !== last_rv + 1) begin errors++;
                        $display("FAIL cont_timing: got grant cycle %0d exp %0d", cyc, last_rv + 1); end
                end
                rv_pend = 1'b1; rv_owner = gnt_idx; rv_data = $urandom;
            end else begin
                rv_pend = 1'b0;
            end
            step();
            cyc++;
        end
        checks++; if (exp_q.size() != 0 || rv_pend) begin errors++;
            $display("FAIL cont_timeout: got %0d grants pending exp 0", exp_q.size()); end
        exp_q.delete();
        clear_inputs();
        step();
    endtask

    task automatic test_unmapped();
        logic [31:0] exp;
        apply_reset();
        m_req_i[1] = 1'b1; m_addr_i[63:32] = 32'h2000_0000; s_gnt_i = 3'b111;
        @(negedge clk);
        checks++; if (m_gnt_o !== 3'b010 || s_req_o !== 3'd0 || m_rvalid_o !== 3'd0) begin errors++;
            $display("FAIL unmap_gnt: got gnt=%b req=%b rvalid=%b exp 010/0/0", m_gnt_o, s_req_o, m_rvalid_o); end
        exp_q.push_back(32'd0);
        step();
        m_req_i[1] = 1'b1;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (m_rvalid_o !== 3'b010 || m_err_o !== 3'b010 || m_rdata_o[63:32] !== exp || m_gnt_o !== 3'd0 || s_req_o !== 3'd0) begin errors++;
            $display("FAIL unmap_resp: got rvalid=%b err=%b data=%h gnt=%b req=%b exp 010/010/0/0/0", m_rvalid_o, m_err_o, m_rdata_o[63:32], m_gnt_o, s_req_o); end
        step();
        m_req_i = '0;
        @(negedge clk);
        checks++; if (m_rvalid_o !== 3'd0 || m_err_o !== 3'd0) begin errors++;
            $display("FAIL unmap_once: got rvalid=%b err=%b exp 0/0", m_rvalid_o, m_err_o); end
        clear_inputs();
        step();
    endtask

    task automatic test_decode_boundaries();
        logic [31:0] addrs [6];
        logic [2:0]  exp_req [6];
        addrs = '{32'h000F_FFFF, 32'h0010_0000, 32'h0FFF_FFFF, 32'h1A11_FFFF, 32'h1A12_0000, 32'h1A0F_FFFF};
        exp_req = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b000, 3'b000};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            m_req_i[0] = 1'b1; m_addr_i[31:0] = addrs[i]; s_gnt_i = '0;
            @(negedge clk);
            checks++; if (s_req_o !== exp_req[i] || m_gnt_o[0] !== (exp_req[i] == 3'd0)) begin errors++;
                $display("FAIL decode_%0d: got req=%b gnt=%b for %h exp req=%b", i, s_req_o, m_gnt_o, addrs[i], exp_req[i]); end
            step();
            m_req_i = '0;
            if (exp_req[i] == 3'd0) begin
                @(negedge clk);
                checks++; if (m_rvalid_o !== 3'b001 || m_err_o !== 3'b001) begin errors++;
                    $display("FAIL decode_err_%0d: got rvalid=%b err=%b exp 001/001", i, m_rvalid_o, m_err_o); end
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_concurrency();
        logic [31:0] w0, w2, a, b, exp;
        apply_reset();
        w0 = $urandom; w2 = $urandom; a = $urandom; b = $urandom;
        m_req_i = 3'b101; m_we_i = 3'b101;
        m_addr_i[31:0] = 32'h0000_0100; m_addr_i[95:64] = 32'h0020_0000;
        m_be_i[3:0] = 4'h3; m_be_i[11:8] = 4'hC;
        m_wdata_i[31:0] = w0; m_wdata_i[95:64] = w2;
        s_gnt_i = 3'b011;
        @(negedge clk);
        checks++; if (m_gnt_o !== 3'b101 || s_req_o !== 3'b011) begin errors++;
            $display("FAIL conc_gnt: got gnt=%b req=%b exp 101/011", m_gnt_o, s_req_o); end
        checks++; if (s_wdata_o[63:0] !== {w2, w0} || s_we_o !== 3'b011 || s_be_o[7:0] !== 8'hC3 || s_addr_o[63:0] !== {32'h0020_0000, 32'h0000_0100}) begin errors++;
            $display("FAIL conc_fwd: got wdata=%h we=%b be=%h addr=%h exp %h/011/c3", s_wdata_o[63:0], s_we_o, s_be_o[7:0], s_addr_o[63:0], {w2, w0}); end
        exp_q.push_back(a); exp_q.push_back(b);
        step();
        clear_inputs();
        s_rvalid_i = 3'b010; s_rdata_i[63:32] = a;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (m_rvalid_o !== 3'b100 || m_rdata_o !== {exp, 64'd0}) begin errors++;
            $display("FAIL conc_resp2: got rvalid=%b data=%h exp 100 data %h", m_rvalid_o, m_rdata_o, exp); end
        step();
        clear_inputs();
        s_rvalid_i = 3'b001; s_rdata_i[31:0] = b;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (m_rvalid_o !== 3'b001 || m_rdata_o !== {64'd0, exp}) begin errors++;
            $display("FAIL conc_resp0: got rvalid=%b data=%h exp 001 data %h", m_rvalid_o, m_rdata_o, exp); end
        step();
        clear_inputs();
    endtask

    task automatic test_grant_stall();
        apply_reset();
        m_req_i = 3'b011; m_addr_i[31:0] = 32'h20; m_addr_i[63:32] = 32'h30;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (m_gnt_o !== 3'd0 || s_req_o !== 3'b001 || s_addr_o[31:0] !== 32'h20) begin errors++;
                $display("FAIL stall_%0d: got gnt=%b req=%b addr=%h exp 0/001/20", c, m_gnt_o, s_req_o, s_addr_o[31:0]); end
            step();
        end
        s_gnt_i[0] = 1'b1;
        @(negedge clk);
        checks++; if (m_gnt_o !== 3'b001) begin errors++;
            $display("FAIL stall_release: got %b exp 001", m_gnt_o); end
        step();
        m_req_i[0] = 1'b0; s_rvalid_i[0] = 1'b1;
        @(negedge clk);
        checks++; if (m_rvalid_o !== 3'b001 || m_gnt_o !== 3'd0) begin errors++;
            $display("FAIL stall_resp: got rvalid=%b gnt=%b exp 001/0", m_rvalid_o, m_gnt_o); end
        step();
        s_rvalid_i = '0;
        @(negedge clk);
        checks++; if (m_gnt_o !== 3'b010 || s_addr_o[31:0] !== 32'h30) begin errors++;
            $display("FAIL stall_next: got gnt=%b addr=%h exp 010/30", m_gnt_o, s_addr_o[31:0]); end
        step();
        // Pointer now at master 2: stall master 1, then let master 2 join.
        m_req_i = 3'b000; s_gnt_i = '0; s_rvalid_i[0] = 1'b1;
        step();
        s_rvalid_i = '0; m_req_i = 3'b010;
        @(negedge clk);
        step();
        m_req_i = 3'b110; m_addr_i[95:64] = 32'h40;
        @(negedge clk);
        checks++; if (s_addr_o[31:0] !== 32'h30 || m_gnt_o !== 3'd0) begin errors++;
            $display("FAIL stall_hold: got addr=%h gnt=%b exp 30/0", s_addr_o[31:0], m_gnt_o); end
        step();
        s_gnt_i[0] = 1'b1;
        @(negedge clk);
        checks++; if (m_gnt_o !== 3'b010) begin errors++;
            $display("FAIL stall_hold_gnt: got %b exp 010", m_gnt_o); end
        step();
        m_req_i = '0; s_gnt_i = '0; s_rvalid_i[0] = 1'b1;
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_req_i[1] = 1'b1; m_addr_i[63:32] = 32'h0010_0000; s_gnt_i[1] = 1'b1;
        @(negedge clk);
        checks++; if (m_gnt_o !== 3'b010 || s_req_o !== 3'b010) begin errors++;
            $display("FAIL rmid_gnt: got gnt=%b req=%b exp 010/010", m_gnt_o, s_req_o); end
        step();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_rvalid_i[1] = 1'b1; s_rdata_i[63:32] = 32'h1234_5678;
        @(negedge clk);
        checks++; if (m_rvalid_o !== 3'd0 || m_rdata_o !== 96'd0 || m_err_o !== 3'd0 || m_gnt_o !== 3'd0) begin errors++;
            $display("FAIL rmid_stale: got rvalid=%b data=%h err=%b gnt=%b exp 0", m_rvalid_o, m_rdata_o, m_err_o, m_gnt_o); end
        checks++; if (s_req_o !== 3'd0 || s_addr_o !== 96'd0 || {dbg_m_state, dbg_s_state} !== 9'd0) begin errors++;
            $display("FAIL rmid_idle: got req=%b addr=%h state=%b exp 0", s_req_o, s_addr_o, {dbg_m_state, dbg_s_state}); end
        step();
        clear_inputs();
        m_req_i[1] = 1'b1; m_addr_i[63:32] = 32'h0010_0004; s_gnt_i[1] = 1'b1;
        @(negedge clk);
        checks++; if (m_gnt_o !== 3'b010 || s_addr_o[63:32] !== 32'h0010_0004) begin errors++;
            $display("FAIL rmid_new_gnt: got gnt=%b addr=%h exp 010/00100004", m_gnt_o, s_addr_o[63:32]); end
        step();
        clear_inputs();
        s_rvalid_i[1] = 1'b1; s_rdata_i[63:32] = 32'hCAFE_0001;
        @(negedge clk);
        checks++; if (m_rvalid_o !== 3'b010 || m_rdata_o[63:32] !== 32'hCAFE_0001) begin errors++;
            $display("FAIL rmid_new_resp: got rvalid=%b data=%h exp 010/cafe0001", m_rvalid_o, m_rdata_o[63:32]); end
        step();
        clear_inputs();
    endtask

    // Sequence and final report
    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_unmapped();
        test_decode_boundaries();
        test_concurrency();
        test_grant_stall();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin errors++;
            $display("FAIL scoreboard_drain: got %0d entries exp 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
